// File: rtl/mux4_1_reg_if.sv
// Stream bundle for the registered 4-to-1 mux: four candidate words plus select
// on a valid/ready input side, and the selected word on a valid/ready output side.
interface mux4_1_reg_if #(
    parameter int WIDTH = 4
);
    logic [WIDTH-1:0] i1;
    logic [WIDTH-1:0] i2;
    logic [WIDTH-1:0] i3;
    logic [WIDTH-1:0] i4;
    logic [1:0]       s;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] ot;
    logic             out_valid;
    logic             out_ready;

    modport master (
        output i1, i2, i3, i4, s, in_valid, out_ready,
        input  in_ready, ot, out_valid
    );

    modport slave (
        input  i1, i2, i3, i4, s, in_valid, out_ready,
        output in_ready, ot, out_valid
    );
endinterface

// File: rtl/mux4_1_reg.sv
// Registered 4-to-1 mux on a valid/ready stream; a main output register plus a
// one-word skid register keep full throughput without a ready path from output to input.
module mux4_1_reg #(
    parameter int WIDTH = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    mux4_1_reg_if.slave    bus
);
    logic [WIDTH-1:0] main_q, main_d;
    logic             main_vld_q, main_vld_d;
    logic [WIDTH-1:0] skid_q, skid_d;
    logic             skid_vld_q, skid_vld_d;
    logic [WIDTH-1:0] sel_word;
    logic             accept;
    logic             xfer;

    // A case mux, so an X on an unselected candidate never reaches the output.
    always_comb begin
        sel_word = bus.i1;
        case (bus.s)
            2'd0: sel_word = bus.i1;
            2'd1: sel_word = bus.i2;
            2'd2: sel_word = bus.i3;
            2'd3: sel_word = bus.i4;
            default: sel_word = bus.i1;
        endcase
    end

    // Ready comes only from registered skid state, gated low while in reset.
    assign bus.in_ready  = rst_n & ~skid_vld_q;
    assign bus.ot        = main_q;
    assign bus.out_valid = main_vld_q;

    assign accept = bus.in_valid & bus.in_ready;
    assign xfer   = main_vld_q & bus.out_ready;

    always_comb begin
        main_d     = main_q;
        main_vld_d = main_vld_q;
        skid_d     = skid_q;
        skid_vld_d = skid_vld_q;
        if (xfer) begin
            if (skid_vld_q) begin
                main_d     = skid_q;
                main_vld_d = 1'b1;
                skid_vld_d = 1'b0;
            end else if (accept) begin
                main_d     = sel_word;
                main_vld_d = 1'b1;
            end else begin
                main_vld_d = 1'b0;
            end
        end else if (accept) begin
            if (!main_vld_q) begin
                main_d     = sel_word;
                main_vld_d = 1'b1;
            end else begin
                skid_d     = sel_word;
                skid_vld_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            main_q     <= '0;
            main_vld_q <= 1'b0;
            skid_q     <= '0;
            skid_vld_q <= 1'b0;
        end else begin
            main_q     <= main_d;
            main_vld_q <= main_vld_d;
            skid_q     <= skid_d;
            skid_vld_q <= skid_vld_d;
        end
    end
endmodule

// File: tb/tb_mux4_1_reg.sv
// Directed and scoreboarded bench for mux4_1_reg: reset, select sweep,
// back-pressure/skid, hold, mid-stream reset and a random soak.
module tb_mux4_1_reg;
    logic clk;
    logic rst_n;
    int   n_chk;
    int   n_fail;

    mux4_1_reg_if #(.WIDTH(4)) bus ();

    mux4_1_reg #(.WIDTH(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rand_inputs();
        bus.i1 = 4'($urandom);
        bus.i2 = 4'($urandom);
        bus.i3 = 4'($urandom);
        bus.i4 = 4'($urandom);
        bus.s  = 2'($urandom);
    endtask

    function automatic logic [3:0] ref_sel(input logic [3:0] a, b, c, d, input logic [1:0] sel);
        case (sel)
            2'd0: return a;
            2'd1: return b;
            2'd2: return c;
            default: return d;
        endcase
    endfunction

    logic [3:0] exp_q[$];
    logic [3:0] exp_w;
    int         sent;
    int         rcvd;
    int         cyc;

    initial begin
        n_chk  = 0;
        n_fail = 0;
        rst_n  = 1'b0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        rand_inputs();

        // Reset with random inputs
        #1;
        for (int k = 0; k < 2; k++) begin
            rand_inputs();
            bus.in_valid  = 1'($urandom);
            bus.out_ready = 1'($urandom);
            tick();
        end
        chk("rst_ot", bus.ot, 4'h0);
        chk("rst_out_valid", bus.out_valid, 1'b0);
        chk("rst_in_ready", bus.in_ready, 1'b0);
        bus.in_valid = 1'b0;
        rst_n = 1'b1;
        #1;
        chk("rel_in_ready", bus.in_ready, 1'b1);

        // Select sweep at full throughput
        bus.i1 = 4'h3; bus.i2 = 4'hA; bus.i3 = 4'h5; bus.i4 = 4'hF;
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b1;
        bus.s = 2'd0; tick();
        chk("sweep_s0", bus.ot, 4'h3);
        chk("sweep_v0", bus.out_valid, 1'b1);
        bus.s = 2'd1; tick();
        chk("sweep_s1", bus.ot, 4'hA);
        chk("sweep_v1", bus.out_valid, 1'b1);
        bus.s = 2'd2; tick();
        chk("sweep_s2", bus.ot, 4'h5);
        chk("sweep_v2", bus.out_valid, 1'b1);
        bus.s = 2'd3; tick();
        chk("sweep_s3", bus.ot, 4'hF);
        chk("sweep_v3", bus.out_valid, 1'b1);
        bus.in_valid = 1'b0; tick();
        chk("sweep_drain", bus.out_valid, 1'b0);

        // Back-pressure into the skid register
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.s = 2'd1; tick();
        chk("bp_first_ot", bus.ot, 4'hA);
        chk("bp_first_v", bus.out_valid, 1'b1);
        chk("bp_first_rdy", bus.in_ready, 1'b1);
        bus.s = 2'd3; tick();
        chk("bp_skid_ot", bus.ot, 4'hA);
        chk("bp_skid_rdy", bus.in_ready, 1'b0);

        // Hold: inputs churn while stalled and full; nothing may change
        for (int k = 0; k < 3; k++) begin
            rand_inputs();
            bus.in_valid = 1'b1;
            tick();
            chk("hold_ot", bus.ot, 4'hA);
            chk("hold_v", bus.out_valid, 1'b1);
            chk("hold_rdy", bus.in_ready, 1'b0);
        end

        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        tick();
        chk("bp_second_ot", bus.ot, 4'hF);
        chk("bp_second_v", bus.out_valid, 1'b1);
        chk("bp_rdy_back", bus.in_ready, 1'b1);
        tick();
        chk("bp_empty", bus.out_valid, 1'b0);

        // Reset while main and skid both hold data
        bus.i1 = 4'h3; bus.i2 = 4'hA; bus.i3 = 4'h5; bus.i4 = 4'hF;
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.s = 2'd0; tick();
        bus.s = 2'd2; tick();
        chk("mid_full", bus.in_ready, 1'b0);
        rst_n = 1'b0;
        bus.in_valid = 1'b0;
        tick();
        chk("mid_rst_v", bus.out_valid, 1'b0);
        chk("mid_rst_ot", bus.ot, 4'h0);
        rst_n = 1'b1;
        bus.out_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("mid_no_old", bus.out_valid, 1'b0);
        end

        // Random soak against a reference selection and an in-order scoreboard
        sent = 0;
        rcvd = 0;
        cyc  = 0;
        while (rcvd < 100 && cyc < 2000) begin
            rand_inputs();
            bus.in_valid  = (sent < 100) ? 1'($urandom) | 1'($urandom) : 1'b0;
            bus.out_ready = 1'($urandom);
            #1;
            if (bus.out_valid && bus.out_ready) begin
                if (exp_q.size() == 0) begin
                    chk("soak_spurious", 1'b1, 1'b0);
                end else begin
                    exp_w = exp_q.pop_front();
                    chk("soak_data", bus.ot, exp_w);
                end
                rcvd++;
            end
            if (bus.in_valid && bus.in_ready) begin
                exp_q.push_back(ref_sel(bus.i1, bus.i2, bus.i3, bus.i4, bus.s));
                sent++;
            end
            tick();
            cyc++;
        end
        chk("soak_count", rcvd, 100);
        chk("soak_left", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
